// File: rtl/gobou_img_arbiter.sv
// Per-cycle arbiter that shares the single-port gobou image memory between the host bus and the gobou core.
// Optional stall statistics are compiled in with `define GOBOU_IMG_STAT_EN.
module gobou_img_arbiter #(
    parameter int DWIDTH  = 16,
    parameter int IMGSIZE = 12
) (
    input  logic                      clk,
    input  logic                      xrst,
`ifdef GOBOU_IMG_STAT_EN
    input  logic                      stat_clr,
    output logic [31:0]               host_stall_cnt,
`endif
    input  logic                      core_lock,
    input  logic                      host_req,
    input  logic                      host_we,
    input  logic [IMGSIZE-1:0]        host_addr,
    input  logic signed [DWIDTH-1:0]  host_wdata,
    output logic                      host_gnt,
    output logic                      host_rvalid,
    output logic signed [DWIDTH-1:0]  host_rdata,
    input  logic                      core_req,
    input  logic [IMGSIZE-1:0]        core_addr,
    output logic                      core_gnt,
    output logic                      core_rvalid,
    output logic signed [DWIDTH-1:0]  core_rdata,
    output logic                      mem_we,
    output logic [IMGSIZE-1:0]        mem_addr,
    output logic signed [DWIDTH-1:0]  mem_wdata,
    input  logic signed [DWIDTH-1:0]  mem_rdata
);

    localparam logic OWNER_HOST = 1'b0;
    localparam logic OWNER_CORE = 1'b1;

    logic                      last_owner_q, last_owner_d;
    logic [IMGSIZE-1:0]        addr_q, addr_d;
    logic                      rd_host_q, rd_host_d;
    logic                      rd_core_q, rd_core_d;
    logic signed [DWIDTH-1:0]  host_hold_q, host_hold_d;
    logic signed [DWIDTH-1:0]  core_hold_q, core_hold_d;

    // Grant selection; grants are suppressed while reset is asserted.
    always_comb begin
        host_gnt = 1'b0;
        core_gnt = 1'b0;
        if (!xrst) begin
            host_gnt = 1'b0;
            core_gnt = 1'b0;
        end else if (host_req && core_req) begin
            if (core_lock || (last_owner_q == OWNER_HOST)) begin
                core_gnt = 1'b1;
            end else begin
                host_gnt = 1'b1;
            end
        end else if (host_req) begin
            host_gnt = 1'b1;
        end else if (core_req) begin
            core_gnt = 1'b1;
        end else begin
            host_gnt = 1'b0;
            core_gnt = 1'b0;
        end
    end

    // Memory drive and next-state for ownership, address hold and read tags.
    always_comb begin
        mem_addr     = addr_q;
        last_owner_d = last_owner_q;
        if (host_gnt) begin
            mem_addr     = host_addr;
            last_owner_d = OWNER_HOST;
        end else if (core_gnt) begin
            mem_addr     = core_addr;
            last_owner_d = OWNER_CORE;
        end else begin
            mem_addr     = addr_q;
            last_owner_d = last_owner_q;
        end
        addr_d    = mem_addr;
        mem_we    = host_gnt & host_we;
        mem_wdata = host_wdata;
        rd_host_d = host_gnt & ~host_we;
        rd_core_d = core_gnt;
    end

    // Read return: live memory data in the valid cycle, otherwise the held copy.
    always_comb begin
        host_hold_d = rd_host_q ? mem_rdata : host_hold_q;
        core_hold_d = rd_core_q ? mem_rdata : core_hold_q;
        host_rvalid = rd_host_q;
        core_rvalid = rd_core_q;
        host_rdata  = host_hold_d;
        core_rdata  = core_hold_d;
    end

    // Arbitration state, read pipeline and data hold registers.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            last_owner_q <= OWNER_HOST;
            addr_q       <= {IMGSIZE{1'b0}};
            rd_host_q    <= 1'b0;
            rd_core_q    <= 1'b0;
            host_hold_q  <= {DWIDTH{1'b0}};
            core_hold_q  <= {DWIDTH{1'b0}};
        end else begin
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            rd_host_q    <= rd_host_d;
            rd_core_q    <= rd_core_d;
            host_hold_q  <= host_hold_d;
            core_hold_q  <= core_hold_d;
        end
    end

`ifdef GOBOU_IMG_STAT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of host stall cycles; clear takes precedence.
    always_comb begin
        if (stat_clr) begin
            stall_cnt_d = 32'h0000_0000;
        end else if (host_req && !host_gnt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'h0000_0001;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            stall_cnt_q <= 32'h0000_0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign host_stall_cnt = stall_cnt_q;
`endif

endmodule
